// File: rtl/stepmotor_seq_ctrl.sv
// stepmotor_seq_ctrl: sequencer for a 4-phase stepper (wave, full or half step), with a
//   programmable step period and step count, a start/busy/done handshake, abort and a
//   signed absolute position.
// Latency: all outputs are registered. A start accepted in cycle T shows busy and the first
//   coil drive at T+1. The first step happens at T+period. done pulses one period after the
//   last step.
// Backpressure: none. start is ignored while busy. abort returns to IDLE in the next cycle
//   without a done pulse.
// Ports: clk/reset (synchronous, active-high); start, abort, mode, dir, steps and period are
//   the command inputs; busy, done, step_pulse, step_phase {B_bar,B,A_bar,A} and pos are outputs.
// Optional macro STEP_HOLD_EN: once a move has completed or been aborted, the coils stay
//   energised on the last phase while IDLE.
module stepmotor_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 24,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic             step_pulse,
  output logic [3:0]       step_phase,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE} state_t;

  // Coil pattern for each phase index: bit0 A, bit1 A_bar, bit2 B, bit3 B_bar.
  function automatic logic [3:0] phase_of(input logic [2:0] i);
    case (i)
      3'd0:    phase_of = 4'b0001;
      3'd1:    phase_of = 4'b0101;
      3'd2:    phase_of = 4'b0100;
      3'd3:    phase_of = 4'b0110;
      3'd4:    phase_of = 4'b0010;
      3'd5:    phase_of = 4'b1010;
      3'd6:    phase_of = 4'b1000;
      default: phase_of = 4'b1001;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_pulse_q, step_pulse_d;
  logic [3:0]       step_phase_q, step_phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
`ifdef STEP_HOLD_EN
  logic             hold_q, hold_d;
`endif

  logic       tick;
  logic [2:0] idx_step;
  logic [2:0] idx_adv;

  // The latched period is never zero, so per_q - 1 cannot underflow.
  assign tick     = (div_q == per_q - DIV_W'(1));
  assign idx_step = (mode_q == 2'b10) ? 3'd1 : 3'd2;
  assign idx_adv  = dir_q ? idx_q + idx_step : idx_q - idx_step;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    rem_d        = rem_q;
    per_d        = per_q;
    div_d        = div_q;
    pos_d        = pos_q;
    done_d       = 1'b0;
    step_pulse_d = 1'b0;
`ifdef STEP_HOLD_EN
    hold_d       = hold_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d = mode;
          dir_d  = dir;
          rem_d  = steps;
          per_d  = (period == '0) ? DIV_W'(1) : period;
          div_d  = '0;
          // Snap idx onto the even (wave) or odd (full) lattice before the first step.
          // Half step keeps idx as it is, so there is no jump in phase.
          case (mode)
            2'b01:   idx_d = {idx_q[2:1], 1'b1};
            2'b10:   idx_d = idx_q;
            default: idx_d = {idx_q[2:1], 1'b0};
          endcase
          if (steps == '0) done_d = 1'b1;
          else             state_d = S_RUN;
        end
      end
      S_RUN, S_SETTLE: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (state_q == S_RUN) begin
            idx_d        = idx_adv;
            pos_d        = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_d        = rem_q - CNT_W'(1);
            step_pulse_d = 1'b1;
            // After the last step the phase is held for one more period in SETTLE.
            if (rem_q == CNT_W'(1)) state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef STEP_HOLD_EN
            hold_d  = 1'b1;
`endif
          end
        end
        // An abort in the same cycle as a step still takes that step. It only stops the move.
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
`ifdef STEP_HOLD_EN
          hold_d  = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
`ifdef STEP_HOLD_EN
    step_phase_d = (busy_d || hold_d) ? phase_of(idx_d) : 4'b0000;
`else
    step_phase_d = busy_d ? phase_of(idx_d) : 4'b0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mode_q       <= '0;
      dir_q        <= 1'b0;
      rem_q        <= '0;
      per_q        <= DIV_W'(1);
      div_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      step_phase_q <= 4'b0000;
      pos_q        <= '0;
`ifdef STEP_HOLD_EN
      hold_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      rem_q        <= rem_d;
      per_q        <= per_d;
      div_q        <= div_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_pulse_q <= step_pulse_d;
      step_phase_q <= step_phase_d;
      pos_q        <= pos_d;
`ifdef STEP_HOLD_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign step_pulse = step_pulse_q;
  assign step_phase = step_phase_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_stepmotor_seq_ctrl.sv
// tb_stepmotor_seq_ctrl: directed bench for stepmotor_seq_ctrl.
// Latency: each scenario samples the outputs 1 time unit after every rising edge, indexed
//   from the edge on which start was taken.
// Backpressure: not applicable. Every scenario runs for a fixed number of cycles.
module tb_stepmotor_seq_ctrl;
  localparam int CNT_W = 16;
  localparam int DIV_W = 24;
  localparam int POS_W = 16;

`ifdef STEP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             dir = 1'b1;
  logic [CNT_W-1:0] steps = '0;
  logic [DIV_W-1:0] period = '0;
  logic             busy, done, step_pulse;
  logic [3:0]       step_phase;
  logic [POS_W-1:0] pos;

  int n_cmp = 0;
  int n_err = 0;

  stepmotor_seq_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .dir(dir),
    .steps(steps), .period(period), .busy(busy), .done(done), .step_pulse(step_pulse),
    .step_phase(step_phase), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // Present a move request for one edge. On return the outputs belong to cycle T+1.
  task automatic launch(input logic [1:0] m, input logic d,
                        input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p);
    mode = m; dir = d; steps = s; period = p; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    do_reset();
    obs = {busy, done, step_pulse, step_phase};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000", obs);
    end
    n_cmp++;
    if (pos !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_pos: got %h want 0000", pos);
    end
  endtask

  task automatic test_wave_fwd();
    logic [6:0] obs, exp;
    logic [3:0] ph;
    do_reset();
    launch(2'b00, 1'b1, 16'd4, 24'd3);
    for (int k = 1; k <= 17; k++) begin
      if      (k < 4)  ph = 4'b0001;
      else if (k < 7)  ph = 4'b0100;
      else if (k < 10) ph = 4'b0010;
      else if (k < 13) ph = 4'b1000;
      else if (k < 16) ph = 4'b0001;
      else             ph = HOLD ? 4'b0001 : 4'b0000;
      exp = {(k <= 15), (k == 16), (k == 4 || k == 7 || k == 10 || k == 13), ph};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL wave_fwd T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      cyc();
    end
    n_cmp++;
    if (pos !== 16'd4) begin
      n_err++;
      $display("FAIL wave_fwd_pos: got %h want 0004", pos);
    end
  endtask

  task automatic test_half_rev();
    logic [6:0] obs, exp;
    logic [3:0] ph;
    do_reset();
    launch(2'b10, 1'b0, 16'd3, 24'd1);
    for (int k = 1; k <= 6; k++) begin
      case (k)
        1:       ph = 4'b0001;
        2:       ph = 4'b1001;
        3:       ph = 4'b1000;
        4:       ph = 4'b1010;
        default: ph = HOLD ? 4'b1010 : 4'b0000;
      endcase
      exp = {(k <= 4), (k == 5), (k >= 2 && k <= 4), ph};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL half_rev T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      cyc();
    end
    n_cmp++;
    if (pos !== 16'hFFFD) begin
      n_err++;
      $display("FAIL half_rev_pos: got %h want fffd", pos);
    end
  endtask

  task automatic test_full_align();
    logic [6:0] obs, exp;
    logic [3:0] ph;
    do_reset();
    launch(2'b01, 1'b1, 16'd2, 24'd2);
    for (int k = 1; k <= 8; k++) begin
      if      (k <= 2) ph = 4'b0101;
      else if (k <= 4) ph = 4'b0110;
      else if (k <= 6) ph = 4'b1010;
      else             ph = HOLD ? 4'b1010 : 4'b0000;
      exp = {(k <= 6), (k == 7), (k == 3 || k == 5), ph};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL full_align T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      cyc();
    end
    n_cmp++;
    if (pos !== 16'd2) begin
      n_err++;
      $display("FAIL full_align_pos: got %h want 0002", pos);
    end
  endtask

  task automatic test_zero_steps();
    logic [6:0] obs, exp;
    do_reset();
    launch(2'b00, 1'b1, 16'd0, 24'd5);
    for (int k = 1; k <= 4; k++) begin
      exp = {1'b0, (k == 1), 1'b0, 4'b0000};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL zero_steps T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      cyc();
    end
  endtask

  task automatic test_period_zero();
    logic [6:0] obs, exp;
    logic [3:0] ph;
    do_reset();
    launch(2'b00, 1'b1, 16'd3, 24'd0);
    for (int k = 1; k <= 6; k++) begin
      case (k)
        1:       ph = 4'b0001;
        2:       ph = 4'b0100;
        3:       ph = 4'b0010;
        4:       ph = 4'b1000;
        default: ph = HOLD ? 4'b1000 : 4'b0000;
      endcase
      exp = {(k <= 4), (k == 5), (k >= 2 && k <= 4), ph};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL period_zero T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      cyc();
    end
    n_cmp++;
    if (pos !== 16'd3) begin
      n_err++;
      $display("FAIL period_zero_pos: got %h want 0003", pos);
    end
  endtask

  task automatic test_abort_ignored_start();
    logic [6:0] obs, exp;
    logic [3:0] ph;
    do_reset();
    launch(2'b10, 1'b1, 16'd10, 24'd2);
    for (int k = 1; k <= 12; k++) begin
      if      (k <= 2) ph = 4'b0001;
      else if (k <= 4) ph = 4'b0101;
      else if (k == 5) ph = 4'b0100;
      else             ph = HOLD ? 4'b0100 : 4'b0000;
      exp = {(k <= 5), 1'b0, (k == 3 || k == 5), ph};
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL abort T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      // Offer a new move while busy, then abort after the second step.
      if (k == 3) begin
        start = 1'b1; mode = 2'b00; dir = 1'b0; steps = 16'd1; period = 24'd1;
      end else begin
        start = 1'b0;
      end
      abort = (k == 5);
      cyc();
    end
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (pos !== 16'd2) begin
      n_err++;
      $display("FAIL abort_pos: got %h want 0002", pos);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] obs, exp;
    do_reset();
    launch(2'b00, 1'b1, 16'd10, 24'd1);
    for (int k = 1; k <= 4; k++) begin
      case (k)
        1:       exp = 7'b1000001;
        2:       exp = 7'b1010100;
        3:       exp = 7'b1010010;
        default: exp = 7'b0000000;
      endcase
      obs = {busy, done, step_pulse, step_phase};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_mid_run T+%0d {busy,done,pulse,phase}: got %b want %b", k, obs, exp);
      end
      reset = (k == 3);
      cyc();
    end
    reset = 1'b0;
    n_cmp++;
    if (pos !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid_run_pos: got %h want 0000", pos);
    end
  endtask

  initial begin
    test_reset();
    test_wave_fwd();
    test_half_rev();
    test_full_align();
    test_zero_steps();
    test_period_zero();
    test_abort_ignored_start();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
